// File: rtl/rca3_segment_sequencer_if.sv
// Valid/ready bundle carrying operand requests in and assembled sums out
// of the segment sequencer.
interface rca3_segment_sequencer_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/rca3_segment_sequencer.sv
// Adds two W-bit operands by time-sharing one N-bit approximate ripple-carry
// slice, least-significant segment first, chaining carry through a register.
module rca3_segment_sequencer #(
    parameter int N    = 8,
    parameter int SEGS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rca3_segment_sequencer_if.slave   bus,
    output logic                      busy
);
    localparam int W  = N * SEGS;
    localparam int SW = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam logic [SW-1:0] LAST_SEG = SW'(SEGS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] seg_idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_reg;
    logic          cout_reg;
    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic [N:0]    slice_carry;
    logic          last_seg;

    // approximate_adder3 cell: exact majority carry, sum taken as the inverted
    // carry (wrong only for the all-zero input pattern).
    function automatic logic [1:0] approx_cell(input logic a, input logic b, input logic c);
        logic cout;
        cout = (a & b) | (a & c) | (b & c);
        return {cout, ~cout | (a & b & c)};
    endfunction

    assign last_seg = (seg_idx == LAST_SEG);

    always_comb begin
        slice_a        = a_reg[int'(seg_idx) * N +: N];
        slice_b        = b_reg[int'(seg_idx) * N +: N];
        slice_sum      = '0;
        slice_carry    = '0;
        slice_carry[0] = carry_reg;
        for (int i = 0; i < N; i++) begin
            {slice_carry[i+1], slice_sum[i]} = approx_cell(slice_a[i], slice_b[i], slice_carry[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_seg)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured only in IDLE, so anything presented while busy is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_idx   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.in_a;
                        b_reg     <= bus.in_b;
                        carry_reg <= bus.in_cin;
                        seg_idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[int'(seg_idx) * N +: N] <= slice_sum;
                    carry_reg                       <= slice_carry[N];
                    if (last_seg) begin
                        cout_reg <= slice_carry[N];
                        seg_idx  <= '0;
                    end else begin
                        seg_idx  <= seg_idx + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = sum_reg;
    assign bus.out_cout  = cout_reg;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_rca3_segment_sequencer.sv
// Randomized self-checking bench for rca3_segment_sequencer (SEGS=4 and SEGS=1
// builds) against a bit-serial truth-table model of the full-width chain.
module tb_rca3_segment_sequencer;
    localparam int N    = 8;
    localparam int SEGS = 4;
    localparam int W    = N * SEGS;
    localparam int W1   = N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy4;
    logic busy1;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    rca3_segment_sequencer_if #(.W(W))  bus4 ();
    rca3_segment_sequencer_if #(.W(W1)) bus1 ();

    rca3_segment_sequencer #(.N(N), .SEGS(SEGS)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave),
        .busy  (busy4)
    );

    rca3_segment_sequencer #(.N(N), .SEGS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave),
        .busy  (busy1)
    );

    // Full-width chain of approximate cells, looked up per bit from truth tables
    // indexed by {a, b, carry}. Returns {cout, sum}.
    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input int width);
        logic [7:0]   sum_tab;
        logic [7:0]   carry_tab;
        logic [W-1:0] s;
        logic         c;
        logic [2:0]   idx;
        sum_tab   = 8'b1001_0111;
        carry_tab = 8'b1110_1000;
        s         = '0;
        c         = cin;
        for (int i = 0; i < width; i++) begin
            idx  = {a[i], b[i], c};
            s[i] = sum_tab[idx];
            c    = carry_tab[idx];
        end
        return {c, s};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one request into the SEGS=4 build, scribbles on the inputs while it
    // is busy, waits (bounded) for the result, stalls, then completes the handshake.
    task automatic op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input int stall, output logic [W-1:0] s, output logic co,
                       output int lat, output bit timed_out);
        bus4.in_a      = a;
        bus4.in_b      = b;
        bus4.in_cin    = cin;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b0;
        tick;
        bus4.in_a     = $urandom;
        bus4.in_b     = $urandom;
        bus4.in_cin   = 1'($urandom);
        bus4.in_valid = 1'($urandom);
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            tick;
            lat++;
        end
        bus4.in_valid = 1'b0;
        timed_out     = !bus4.out_valid;
        s             = bus4.out_sum;
        co            = bus4.out_cout;
        repeat (stall) tick;
        bus4.out_ready = 1'b1;
        tick;
        bus4.out_ready = 1'b0;
    endtask

    task automatic op1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin,
                       output logic [W1-1:0] s, output logic co, output int lat,
                       output bit timed_out);
        bus1.in_a      = a;
        bus1.in_b      = b;
        bus1.in_cin    = cin;
        bus1.in_valid  = 1'b1;
        bus1.out_ready = 1'b0;
        tick;
        bus1.in_a     = 8'($urandom);
        bus1.in_b     = 8'($urandom);
        bus1.in_valid = 1'($urandom);
        lat = 0;
        while (!bus1.out_valid && lat < 40) begin
            tick;
            lat++;
        end
        bus1.in_valid = 1'b0;
        timed_out     = !bus1.out_valid;
        s             = bus1.out_sum;
        co            = bus1.out_cout;
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (bus4.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus4.out_valid); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy4); end
        checks++; if (bus4.out_sum !== '0) begin fails++; $display("[TB] FAIL reset_out_sum: got %h want 0", bus4.out_sum); end
        checks++; if (bus4.out_cout !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_cout: got %b want 0", bus4.out_cout); end
        checks++; if (bus1.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready_seg1: got %b want 1", bus1.in_ready); end
        tick;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_zero_operands;
        logic [W:0]   expv;
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           busy_cnt;
        expv = model_add('0, '0, 1'b0, W);
        s    = '0;
        co   = 1'b0;
        bus4.in_a      = '0;
        bus4.in_b      = '0;
        bus4.in_cin    = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        tick;
        bus4.in_valid = 1'b0;
        busy_cnt = 0;
        lat      = -1;
        for (int k = 0; k < 8; k++) begin
            if (busy4) busy_cnt++;
            if (bus4.out_valid && lat < 0) begin
                lat = k;
                s   = bus4.out_sum;
                co  = bus4.out_cout;
            end
            tick;
        end
        bus4.out_ready = 1'b0;
        checks++; if (lat != SEGS) begin fails++; $display("[TB] FAIL zero_latency: got %0d want %0d", lat, SEGS); end
        checks++; if (s !== expv[W-1:0]) begin fails++; $display("[TB] FAIL zero_sum: got %h want %h", s, expv[W-1:0]); end
        checks++; if (co !== expv[W]) begin fails++; $display("[TB] FAIL zero_cout: got %b want %b", co, expv[W]); end
        checks++; if (busy_cnt != SEGS + 1) begin fails++; $display("[TB] FAIL zero_busy_cycles: got %0d want %0d", busy_cnt, SEGS + 1); end
    endtask

    task automatic test_carry_chain;
        logic [W:0]   expv;
        logic [W-1:0] s;
        logic         co;
        int           lat;
        bit           to;
        expv = model_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, W);
        op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0, s, co, lat, to);
        checks++; if (to || lat != SEGS) begin fails++; $display("[TB] FAIL chain_latency: got %0d want %0d", lat, SEGS); end
        checks++; if (s !== expv[W-1:0]) begin fails++; $display("[TB] FAIL chain_sum: got %h want %h", s, expv[W-1:0]); end
        checks++; if (co !== expv[W]) begin fails++; $display("[TB] FAIL chain_cout: got %b want %b", co, expv[W]); end
    endtask

    task automatic test_backpressure;
        logic [W:0] expv;
        int         lat;
        expv = model_add(32'h1234_5678, 32'h8765_4321, 1'b0, W);
        bus4.in_a      = 32'h1234_5678;
        bus4.in_b      = 32'h8765_4321;
        bus4.in_cin    = 1'b0;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b0;
        tick;
        bus4.in_a   = 32'hDEAD_BEEF;
        bus4.in_b   = 32'h0BAD_F00D;
        bus4.in_cin = 1'b1;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            tick;
            lat++;
        end
        checks++; if (lat != SEGS) begin fails++; $display("[TB] FAIL stall_latency: got %0d want %0d", lat, SEGS); end
        for (int k = 0; k < 10; k++) begin
            checks++; if (bus4.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_valid cycle %0d: got %b want 1", k, bus4.out_valid); end
            checks++; if (bus4.out_sum !== expv[W-1:0]) begin fails++; $display("[TB] FAIL stall_sum cycle %0d: got %h want %h", k, bus4.out_sum, expv[W-1:0]); end
            checks++; if (bus4.out_cout !== expv[W]) begin fails++; $display("[TB] FAIL stall_cout cycle %0d: got %b want %b", k, bus4.out_cout, expv[W]); end
            checks++; if (bus4.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready cycle %0d: got %b want 0", k, bus4.in_ready); end
            tick;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        tick;
        bus4.out_ready = 1'b0;
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release_valid: got %b want 0", bus4.out_valid); end
        checks++; if (bus4.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_release_ready: got %b want 1", bus4.in_ready); end
        tick;
        checks++; if (busy4 !== 1'b0) begin fails++; $display("[TB] FAIL stall_ignored_request: busy %b want 0", busy4); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xa, xb, ya, yb;
        logic         xc, yc;
        logic [W:0]   ex, ey;
        logic [W-1:0] res_s [2];
        logic         res_c [2];
        int           acc_t [2];
        int           accepts, results, t;
        logic         prev_busy;
        xa = $urandom; xb = $urandom; xc = 1'($urandom);
        ya = $urandom; yb = $urandom; yc = 1'($urandom);
        ex = model_add(xa, xb, xc, W);
        ey = model_add(ya, yb, yc, W);
        for (int i = 0; i < 2; i++) begin
            res_s[i] = '0; res_c[i] = 1'b0; acc_t[i] = 0;
        end
        bus4.in_a      = xa;
        bus4.in_b      = xb;
        bus4.in_cin    = xc;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        accepts   = 0;
        results   = 0;
        t         = 0;
        prev_busy = busy4;
        while (t < 40 && (accepts < 2 || results < 2)) begin
            tick;
            t++;
            if (busy4 && !prev_busy && accepts < 2) begin
                acc_t[accepts] = t;
                accepts++;
                if (accepts == 1) begin
                    bus4.in_a   = ya;
                    bus4.in_b   = yb;
                    bus4.in_cin = yc;
                end else begin
                    bus4.in_valid = 1'b0;
                end
            end
            if (bus4.out_valid && results < 2) begin
                res_s[results] = bus4.out_sum;
                res_c[results] = bus4.out_cout;
                results++;
            end
            prev_busy = busy4;
        end
        bus4.in_valid = 1'b0;
        tick;
        bus4.out_ready = 1'b0;
        checks++; if (accepts != 2 || results != 2) begin fails++; $display("[TB] FAIL b2b_counts: accepts %0d results %0d want 2 2", accepts, results); end
        checks++; if (acc_t[1] - acc_t[0] != SEGS + 2) begin fails++; $display("[TB] FAIL b2b_spacing: got %0d want %0d", acc_t[1] - acc_t[0], SEGS + 2); end
        checks++; if (res_s[0] !== ex[W-1:0] || res_c[0] !== ex[W]) begin fails++; $display("[TB] FAIL b2b_first: got %b_%h want %b_%h", res_c[0], res_s[0], ex[W], ex[W-1:0]); end
        checks++; if (res_s[1] !== ey[W-1:0] || res_c[1] !== ey[W]) begin fails++; $display("[TB] FAIL b2b_second: got %b_%h want %b_%h", res_c[1], res_s[1], ey[W], ey[W-1:0]); end
    endtask

    task automatic test_reset_abort;
        logic [W:0]   expv;
        logic [W-1:0] s;
        logic         co;
        int           lat;
        bit           to;
        bus4.in_a      = 32'hA5A5_5A5A;
        bus4.in_b      = 32'h0F0F_F0F0;
        bus4.in_cin    = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b0;
        tick;
        bus4.in_valid = 1'b0;
        tick;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_run_valid: got %b want 0", bus4.out_valid); end
        checks++; if (busy4 !== 1'b0) begin fails++; $display("[TB] FAIL abort_run_busy: got %b want 0", busy4); end
        checks++; if (bus4.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL abort_run_in_ready: got %b want 1", bus4.in_ready); end
        checks++; if (bus4.out_sum !== '0) begin fails++; $display("[TB] FAIL abort_run_sum: got %h want 0", bus4.out_sum); end
        #1 rst_n = 1'b1;
        tick;
        expv = model_add(32'd5, 32'd3, 1'b0, W);
        op4(32'd5, 32'd3, 1'b0, 0, s, co, lat, to);
        checks++; if (to || lat != SEGS) begin fails++; $display("[TB] FAIL after_abort_latency: got %0d want %0d", lat, SEGS); end
        checks++; if (s !== expv[W-1:0] || co !== expv[W]) begin fails++; $display("[TB] FAIL after_abort_result: got %b_%h want %b_%h", co, s, expv[W], expv[W-1:0]); end
        bus4.in_a      = 32'hFFFF_0000;
        bus4.in_b      = 32'h00FF_FF00;
        bus4.in_cin    = 1'b1;
        bus4.in_valid  = 1'b1;
        tick;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 40) begin
            tick;
            lat++;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus4.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_done_valid: got %b want 0", bus4.out_valid); end
        checks++; if (bus4.out_sum !== '0 || bus4.out_cout !== 1'b0) begin fails++; $display("[TB] FAIL abort_done_result: got %b_%h want 0_0", bus4.out_cout, bus4.out_sum); end
        #1 rst_n = 1'b1;
        tick;
    endtask

    task automatic test_random;
        logic [W-1:0]  a, b, s;
        logic [W1-1:0] a1, b1, s1;
        logic          cin, co;
        logic [W:0]    expv;
        int            lat, sel;
        bit            to;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 5);
            a   = (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h0 : 32'($urandom);
            b   = (sel == 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            cin = 1'($urandom);
            expv = model_add(a, b, cin, W);
            op4(a, b, cin, $urandom_range(0, 3), s, co, lat, to);
            checks++; if (to || lat != SEGS) begin fails++; $display("[TB] FAIL rand_latency op %0d: got %0d want %0d", n, lat, SEGS); end
            checks++; if (s !== expv[W-1:0] || co !== expv[W]) begin fails++; $display("[TB] FAIL rand_result op %0d a=%h b=%h cin=%b: got %b_%h want %b_%h", n, a, b, cin, co, s, expv[W], expv[W-1:0]); end
        end
        for (int n = 0; n < 500; n++) begin
            a1   = 8'($urandom);
            b1   = 8'($urandom);
            cin  = 1'($urandom);
            expv = model_add(W'(a1), W'(b1), cin, W1);
            op1(a1, b1, cin, s1, co, lat, to);
            checks++; if (to || lat != 1) begin fails++; $display("[TB] FAIL seg1_latency op %0d: got %0d want 1", n, lat); end
            checks++; if (s1 !== expv[W1-1:0] || co !== expv[W]) begin fails++; $display("[TB] FAIL seg1_result op %0d a=%h b=%h cin=%b: got %b_%h want %b_%h", n, a1, b1, cin, co, s1, expv[W], expv[W1-1:0]); end
        end
    endtask

    initial begin
        bus4.in_valid  = 1'b0;
        bus4.in_a      = '0;
        bus4.in_b      = '0;
        bus4.in_cin    = 1'b0;
        bus4.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_cin    = 1'b0;
        bus1.out_ready = 1'b0;
        test_reset;
        test_zero_operands;
        test_carry_chain;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time %0t reached, limit 2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
